pm_axil_monitor: RTL and testbench
==================================

PM_AXIL_MONITOR -- requirements
Module: pm_axil_monitor

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: AXI data width; only 32 is legal.
REQ-002 Parameter NUM_REGS, default 8: number of 32-bit register slots; legal range 4..64.
REQ-003 Parameter C_S_AXI_ADDR_WIDTH, default 8: byte address width; must satisfy 2^C_S_AXI_ADDR_WIDTH >= 4*NUM_REGS.
REQ-004 Port ACLK, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 Port ARESET, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Write address channel: S_AXI_AWADDR input C_S_AXI_ADDR_WIDTH bits, S_AXI_AWPROT input 3 bits (ignored), S_AXI_AWVALID input 1 bit, S_AXI_AWREADY output 1 bit.
REQ-007 Write data channel: S_AXI_WDATA input 32 bits, S_AXI_WSTRB input 4 bits, S_AXI_WVALID input 1 bit, S_AXI_WREADY output 1 bit.
REQ-008 Write response channel: S_AXI_BRESP output 2 bits, S_AXI_BVALID output 1 bit, S_AXI_BREADY input 1 bit.
REQ-009 Read address channel: S_AXI_ARADDR input C_S_AXI_ADDR_WIDTH bits, S_AXI_ARPROT input 3 bits (ignored), S_AXI_ARVALID input 1 bit, S_AXI_ARREADY output 1 bit.
REQ-010 Read data channel: S_AXI_RDATA output 32 bits, S_AXI_RRESP output 2 bits, S_AXI_RVALID output 1 bit, S_AXI_RREADY input 1 bit.
REQ-011 Port sample_valid, input, 1 bit: marks a sensor sample on this cycle.
REQ-012 Port sample_data, input, 32 bits: unsigned sensor sample.
REQ-013 Port alarm, output, 1 bit: sticky predictive-maintenance alarm (equals STATUS[0]).

Function
REQ-014 Register map (word index = ADDR[..:2]):
- 0 CTRL RW: [0] enable, [1] irq_mask, [15:8] persist limit L.
- 1 THRESH RW.
- 2 SAMPLE RO: last accepted sample.
- 3 STATUS: [0] alarm, [15:8] consecutive-exceed count C; other bits read 0.
- 4..NUM_REGS-1 SCRATCH RW.
REQ-015 AW and W shall be accepted independently, in either order or in the same cycle.
REQ-016 Ready rules: AWREADY = no address held and BVALID low; WREADY = no data held and BVALID low.
REQ-017 The register write shall occur on the edge at which both address and data are held or being accepted; BVALID shall rise on that same edge and hold until BREADY.
REQ-018 Writes shall honour WSTRB per byte.
REQ-019 Writes to SAMPLE shall be ignored with BRESP=OKAY.
REQ-020 A write to STATUS with WSTRB[0] and WDATA[0] both set shall clear alarm and C; all other STATUS bits are not writable.
REQ-021 An address with word index >= NUM_REGS shall produce no register update and BRESP=SLVERR (2'b10); on reads it shall return RDATA=0 and RRESP=SLVERR.
REQ-022 ARREADY shall equal !RVALID; RDATA/RRESP shall be captured on AR handshake, RVALID shall assert the next cycle, and both shall hold stable until RREADY.
REQ-023 Sample handling when enable=1 and sample_valid=1:
- SAMPLE <= sample_data.
- If sample_data > THRESH (unsigned): C <= min(C+1, 255); otherwise C <= 0.
- alarm sets when the new C >= max(L, 1).
REQ-024 When enable=0, samples shall be ignored and C and alarm shall hold.
REQ-025 A STATUS clear in the same cycle as a sample: the clear wins for C and alarm; SAMPLE still updates.
REQ-026 A THRESH write in the same cycle as a sample: the sample compares against the old THRESH.

Reset
REQ-027 While ARESET=1, asynchronously:
- all registers, C, alarm and held AW/W state shall be 0;
- AWREADY, WREADY, BVALID, ARREADY and RVALID shall be 0;
- BRESP, RRESP and RDATA shall be 0.
REQ-028 On the first edge after ARESET deasserts, AWREADY, WREADY and ARREADY shall be 1; an in-flight transaction cut by reset is discarded without a response.

Configuration
REQ-029 Macro PM_ALARM_IRQ_EN:
- Defined: adds output port irq (1 bit), registered, equal to alarm & irq_mask with one-cycle latency.
- Undefined: irq port is absent and CTRL[1] reads 0 and is not writable.

Verification
REQ-030 After reset, write 0x1..0x4 to words 0..3, then read back -> CTRL=0x00000001, THRESH=0x2, SAMPLE=0, STATUS=0; all responses OKAY.
REQ-031 W presented 3 cycles before AW to SCRATCH word 4 (WDATA=0xA5A5A5A5, WSTRB=4'b0101) -> readback 0x00A500A5, BVALID exactly once.
REQ-032 CTRL=0x0301, THRESH=100, samples 101,150,99,120,130,140 -> C goes 1,2,0,1,2,3; alarm rises after the sixth sample; SAMPLE reads 140.
REQ-033 Read and write to word index NUM_REGS -> RRESP=SLVERR with RDATA=0; BRESP=SLVERR; no register changed.
REQ-034 STATUS clear in the same cycle as an exceeding sample with alarm=1 -> alarm=0, C=0, SAMPLE updated; with PM_ALARM_IRQ_EN and irq_mask=1, irq falls one cycle later.
REQ-035 ARESET pulse during a held RVALID with RREADY=0 -> RVALID=0 immediately (asynchronously) and all registers read 0 afterwards.

Source files
------------

// File: rtl/pm_axil_monitor_if.sv
// AXI4-Lite slave bus bundle for pm_axil_monitor; signal names follow the AXI S_AXI_* convention.
interface pm_axil_monitor_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/pm_axil_monitor.sv
// AXI4-Lite register block with a sticky threshold-persistence alarm for sensor samples.
// Optional feature macro PM_ALARM_IRQ_EN adds a registered irq output gated by CTRL[1].
module pm_axil_monitor #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 8,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic        ACLK,
    input  logic        ARESET,
    pm_axil_monitor_if.slave s_axi,
    input  logic        sample_valid,
    input  logic [31:0] sample_data,
    output logic        alarm
`ifdef PM_ALARM_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef PM_ALARM_IRQ_EN
    localparam logic [31:0] CTRL_WMASK = 32'h0000_FF03;
`else
    localparam logic [31:0] CTRL_WMASK = 32'h0000_FF01;
`endif

    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    logic                          live_q;
    logic                          aw_held_q, w_held_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]                   wdata_q;
    logic [3:0]                    wstrb_q;
    logic                          bvalid_q, rvalid_q;
    logic [1:0]                    bresp_q, rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [31:0]                   ctrl_q, thresh_q, sample_q, sample_d;
    logic [7:0]                    cnt_q, cnt_d, lim_eff;
    logic                          alarm_q, alarm_d;
    logic [31:0]                   scratch_q [4:NUM_REGS-1];

    logic                          aw_hs, w_hs, ar_hs, wr_fire, wr_ok, rd_ok, status_clr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]                   wr_data, rd_word;
    logic [3:0]                    wr_strb;
    idx_t                          wr_idx, rd_idx;
    logic                          unused_ok;

    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, wr_addr[1:0],
                         s_axi.S_AXI_ARADDR[1:0]};

    // live_q keeps every ready low until the first edge after reset release
    assign s_axi.S_AXI_AWREADY = live_q & ~aw_held_q & ~bvalid_q;
    assign s_axi.S_AXI_WREADY  = live_q & ~w_held_q & ~bvalid_q;
    assign s_axi.S_AXI_ARREADY = live_q & ~rvalid_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign alarm               = alarm_q;

    assign aw_hs   = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
    assign w_hs    = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
    assign ar_hs   = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
    assign wr_fire = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_addr = aw_held_q ? awaddr_q : s_axi.S_AXI_AWADDR;
    assign wr_data = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
    assign wr_strb = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;
    assign wr_idx  = wr_addr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_ok   = {1'b0, wr_idx} < NREGS;
    assign rd_ok   = {1'b0, rd_idx} < NREGS;

    assign status_clr = wr_fire & (wr_idx == idx_t'(3)) & wr_strb[0] & wr_data[0];
    assign lim_eff    = (ctrl_q[15:8] == 8'd0) ? 8'd1 : ctrl_q[15:8];

    // Sample path uses pre-edge CTRL/THRESH, so a same-cycle write only affects later samples
    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        alarm_d  = alarm_q;
        if (ctrl_q[0] && sample_valid) begin
            sample_d = sample_data;
            if (sample_data > thresh_q)
                cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
            else
                cnt_d = '0;
            if (cnt_d >= lim_eff) alarm_d = 1'b1;
        end
        if (status_clr) begin
            cnt_d   = '0;
            alarm_d = 1'b0;
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            idx_t'(0): rd_word = ctrl_q;
            idx_t'(1): rd_word = thresh_q;
            idx_t'(2): rd_word = sample_q;
            idx_t'(3): rd_word = {16'h0, cnt_q, 7'h0, alarm_q};
            default:
                for (int unsigned i = 4; i < NUM_REGS; i++)
                    if (rd_idx == idx_t'(i)) rd_word = scratch_q[i];
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            live_q    <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            thresh_q  <= '0;
            sample_q  <= '0;
            cnt_q     <= '0;
            alarm_q   <= 1'b0;
            for (int unsigned i = 4; i < NUM_REGS; i++) scratch_q[i] <= '0;
        end else begin
            live_q   <= 1'b1;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            alarm_q  <= alarm_d;

            if (wr_fire) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    awaddr_q  <= s_axi.S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= s_axi.S_AXI_WDATA;
                    wstrb_q  <= s_axi.S_AXI_WSTRB;
                end
                if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_q <= 1'b0;
            end

            if (wr_fire && wr_ok) begin
                case (wr_idx)
                    idx_t'(0): ctrl_q   <= apply_strb(ctrl_q, wr_data, wr_strb) & CTRL_WMASK;
                    idx_t'(1): thresh_q <= apply_strb(thresh_q, wr_data, wr_strb);
                    idx_t'(2), idx_t'(3): ;
                    default:
                        for (int unsigned i = 4; i < NUM_REGS; i++)
                            if (wr_idx == idx_t'(i))
                                scratch_q[i] <= apply_strb(scratch_q[i], wr_data, wr_strb);
                endcase
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

`ifdef PM_ALARM_IRQ_EN
    logic irq_q;
    assign irq = irq_q;
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) irq_q <= 1'b0;
        else        irq_q <= alarm_q & ctrl_q[1];
    end
`endif
endmodule

// File: tb/tb_pm_axil_monitor.sv
// Scoreboard bench for pm_axil_monitor: stimulus queues expected B/R responses, a monitor pops and compares.
module tb_pm_axil_monitor;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic        alarm;
`ifdef PM_ALARM_IRQ_EN
    logic        irq;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      exp_r[$];
    logic [1:0] exp_b[$];
    int checks = 0;
    int errors = 0;
    int bcount = 0;

    pm_axil_monitor_if #(.C_S_AXI_ADDR_WIDTH(8), .C_S_AXI_DATA_WIDTH(32)) bus ();

    pm_axil_monitor #(.C_S_AXI_DATA_WIDTH(32), .NUM_REGS(8), .C_S_AXI_ADDR_WIDTH(8)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .s_axi       (bus),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .alarm       (alarm)
`ifdef PM_ALARM_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: a handshake completes on the posedge after a negedge seeing VALID&READY
    always @(negedge ACLK) begin
        if (!ARESET && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
            bcount++;
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL bresp_unexpected: got %b expected none", bus.S_AXI_BRESP);
            end else begin
                chk("bresp", {30'h0, bus.S_AXI_BRESP}, {30'h0, exp_b.pop_front()});
            end
        end
        if (!ARESET && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
            if (exp_r.size() == 0) begin
                checks++; errors++;
                $display("FAIL rdata_unexpected: got %h expected none", bus.S_AXI_RDATA);
            end else begin
                rexp_t e;
                e = exp_r.pop_front();
                chk($sformatf("rdata@%h", e.addr), bus.S_AXI_RDATA, e.data);
                chk($sformatf("rresp@%h", e.addr), {30'h0, bus.S_AXI_RRESP}, {30'h0, e.resp});
            end
        end
    end

    // All tasks start and end at posedge+1
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp,
                             input int unsigned lead);
        logic aw_pend, w_pend, aw_f, w_f;
        aw_pend = 1'b1; w_pend = 1'b1;
        exp_b.push_back(resp);
        bus.S_AXI_AWADDR = addr;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        bus.S_AXI_WVALID = 1'b1;
        for (int unsigned k = 0; k < 200 && (aw_pend || w_pend); k++) begin
            if (lead > 0 && k == lead)
                chk("bvalid_before_aw", {31'h0, bus.S_AXI_BVALID}, 32'h0);
            if (k >= lead && aw_pend) bus.S_AXI_AWVALID = 1'b1;
            @(negedge ACLK);
            aw_f = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_f  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_f) begin bus.S_AXI_AWVALID = 1'b0; aw_pend = 1'b0; end
            if (w_f)  begin bus.S_AXI_WVALID  = 1'b0; w_pend  = 1'b0; end
        end
        if (aw_pend || w_pend) begin
            checks++; errors++;
            $display("FAIL write_timeout: got pending aw=%0d w=%0d expected 0", aw_pend, w_pend);
            bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input logic expect_resp);
        logic done, f;
        done = 1'b0;
        if (expect_resp) exp_r.push_back('{addr: addr, data: data, resp: resp});
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        for (int unsigned k = 0; k < 200 && !done; k++) begin
            @(negedge ACLK);
            f = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (f) begin bus.S_AXI_ARVALID = 1'b0; done = 1'b1; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL read_timeout: got no AR handshake expected one");
            bus.S_AXI_ARVALID = 1'b0;
        end
    endtask

    task automatic drain();
        for (int unsigned k = 0; k < 100 && (exp_b.size() != 0 || exp_r.size() != 0); k++) begin
            @(posedge ACLK); #1;
        end
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_b.size() + exp_r.size());
            exp_b.delete(); exp_r.delete();
        end
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
        axi_read(addr, data, resp, 1'b1);
        drain();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
        axi_write(addr, data, 4'hF, resp, 0);
        drain();
    endtask

    task automatic sample(input logic [31:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        @(posedge ACLK); #1;
        sample_valid = 1'b0;
    endtask

    // Full-strobe AW+W presented together with a sample so all land on one edge
    task automatic write_with_sample(input logic [7:0] addr, input logic [31:0] data,
                                     input logic [31:0] d);
        exp_b.push_back(2'b00);
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        sample_valid      = 1'b1;
        sample_data       = d;
        @(negedge ACLK);
        chk("same_cycle_ready", {30'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'h3);
        @(posedge ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        sample_valid      = 1'b0;
    endtask

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;
`ifdef PM_ALARM_IRQ_EN
    localparam logic [31:0] CTRL_0303 = 32'h0000_0303;
`else
    localparam logic [31:0] CTRL_0303 = 32'h0000_0301;
`endif

    initial begin
        int unsigned smp [6];
        logic [31:0] est [6];
        int b0;
        smp = '{101, 150, 99, 120, 130, 140};
        est = '{32'h100, 32'h200, 32'h0, 32'h100, 32'h200, 32'h301};

        ARESET = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;

        #1;
        chk("reset_readies", {29'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'h0);
        chk("reset_valids", {30'h0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'h0);
        chk("reset_rdata", bus.S_AXI_RDATA, 32'h0);
        @(posedge ACLK); @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        chk("post_reset_readies", {29'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'h7);
        chk("post_reset_alarm", {31'h0, alarm}, 32'h0);

        for (int unsigned i = 0; i < 4; i++) wr(8'(4 * i), 32'(i + 1), OK);
        rd(8'h00, 32'h1, OK);
        rd(8'h04, 32'h2, OK);
        rd(8'h08, 32'h0, OK);
        rd(8'h0C, 32'h0, OK);

        b0 = bcount;
        axi_write(8'h10, 32'hA5A5A5A5, 4'b0101, OK, 3);
        drain();
        repeat (3) begin @(posedge ACLK); #1; end
        chk("bvalid_count", 32'(bcount - b0), 32'h1);
        rd(8'h10, 32'h00A500A5, OK);

        wr(8'h00, 32'h0301, OK);
        wr(8'h04, 32'd100, OK);
        for (int unsigned i = 0; i < 6; i++) begin
            sample(smp[i]);
            chk($sformatf("alarm_after_sample%0d", i), {31'h0, alarm}, {31'h0, i == 5});
            rd(8'h0C, est[i], OK);
        end
        rd(8'h08, 32'd140, OK);

        wr(8'h00, 32'h0303, OK);
        rd(8'h00, CTRL_0303, OK);
`ifdef PM_ALARM_IRQ_EN
        chk("irq_high", {31'h0, irq}, 32'h1);
`endif
        write_with_sample(8'h0C, 32'h1, 32'd200);
        chk("clear_wins_alarm", {31'h0, alarm}, 32'h0);
`ifdef PM_ALARM_IRQ_EN
        chk("irq_lag", {31'h0, irq}, 32'h1);
        @(posedge ACLK); #1;
        chk("irq_fall", {31'h0, irq}, 32'h0);
`endif
        drain();
        rd(8'h0C, 32'h0, OK);
        rd(8'h08, 32'd200, OK);

        write_with_sample(8'h04, 32'd300, 32'd200);
        drain();
        rd(8'h0C, 32'h100, OK);
        rd(8'h04, 32'd300, OK);

        wr(8'h00, 32'h0300, OK);
        sample(32'd500);
        rd(8'h0C, 32'h100, OK);
        rd(8'h08, 32'd200, OK);

        rd(8'h20, 32'h0, ERR);
        rd(8'hFC, 32'h0, ERR);
        wr(8'h20, 32'hDEADBEEF, ERR);
        wr(8'h08, 32'h12345678, OK);
        rd(8'h00, 32'h300, OK);
        rd(8'h04, 32'd300, OK);
        rd(8'h08, 32'd200, OK);
        rd(8'h10, 32'h00A500A5, OK);
        for (int unsigned i = 5; i < 8; i++) rd(8'(4 * i), 32'h0, OK);

        bus.S_AXI_RREADY = 1'b0;
        axi_read(8'h10, 32'h0, OK, 1'b0);
        @(negedge ACLK);
        chk("rvalid_held", {31'h0, bus.S_AXI_RVALID}, 32'h1);
        @(posedge ACLK); #3;
        ARESET = 1'b1;
        #1;
        chk("async_rvalid_clear", {31'h0, bus.S_AXI_RVALID}, 32'h0);
        chk("async_readies", {29'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'h0);
        @(posedge ACLK); @(posedge ACLK); #1;
        ARESET = 1'b0;
        bus.S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        for (int unsigned i = 0; i < 8; i++) rd(8'(4 * i), 32'h0, OK);
        chk("alarm_after_reset", {31'h0, alarm}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
